// File: rtl/fetch_pkg.sv
// Shared fetch-unit types: group geometry, boot PC, FSM states
// and the stage1 group bundle carried through fetch_s1_reg.
package fetch_pkg;

  localparam int FETCH_W   = 4;
  localparam int GRP_BYTES = 16;

  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    MISS
  } fsm_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [FETCH_W-1:0] vld;
    logic               taken;
    logic [31:0]        target;
  } s1_grp_t;

  // Start of the next 16 B group; wraps to 0 at the top.
  function automatic logic [31:0] seq_pc(
    input logic [31:0] pc
  );
    return {pc[31:4] + 28'd1, 4'b0000};
  endfunction

endpackage

// File: rtl/fetch_s1_reg.sv
// Stage1 pipeline register: group pc/mask/prediction, valid bit
// and a one-cycle flush pulse when a live group is discarded.
module fetch_s1_reg
  import fetch_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    fire_i,
  input  logic    adv_i,
  input  logic    flush_i,
  input  s1_grp_t grp_i,
  output s1_grp_t grp_o,
  output logic    valid_o,
  output logic    flush_o
);

  s1_grp_t grp_q;
  logic    valid_q, valid_d;
  logic    flush_q;

  always_comb begin
    valid_d = valid_q;
    if (flush_i)     valid_d = 1'b0;
    else if (fire_i) valid_d = 1'b1;
    else if (adv_i)  valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      flush_q <= flush_i & valid_q;
      if (fire_i) grp_q <= grp_i;
    end
  end

  assign grp_o   = grp_q;
  assign valid_o = valid_q;
  assign flush_o = flush_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: boot/run/miss FSM, next-PC mux
// (redirect > BTB > sequential) and stage1 handshake to fetch queue.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned BOOT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_s0,
  input  logic        btb_hit,
  input  logic [31:0] btb_target,
  input  logic [3:0]  inst_vld_s0,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        ic_req,
  input  logic        ic_req_rdy,
  input  logic        ic_rsp_vld,
  input  logic        fq_ready,
  output logic        fq_push,
  output logic [31:0] fq_pc,
  output logic [3:0]  fq_vld,
  output logic        fq_pred_taken,
  output logic [31:0] fq_pred_target,
  output logic        stage1_hold,
  output logic        flush_s1
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYC - 1);

  fsm_e        state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pred_pc;
  logic        s1_valid;
  logic        s1_adv;
  logic        fire;
  s1_grp_t     grp_s0, grp_s1;

  assign s1_adv      = !s1_valid | (ic_rsp_vld & fq_ready);
  assign stage1_hold = !s1_adv;
  assign ic_req      = (state_q == RUN) & s1_adv & !redirect_en;
  assign fire        = ic_req & ic_req_rdy;
  assign fq_push     = s1_valid & ic_rsp_vld & fq_ready
                     & !redirect_en;

  assign pred_pc = btb_hit ? btb_target : seq_pc(pc_q);
  assign pc_s0   = pc_q;

  assign grp_s0 = '{
    pc:     pc_q,
    vld:    inst_vld_s0,
    taken:  btb_hit,
    target: pred_pc
  };

  // ic_req is gated by redirect_en, so the two arms never overlap.
  always_comb begin
    pc_d = pc_q;
    unique case (1'b1)
      redirect_en: pc_d = {redirect_pc[31:2], 2'b00};
      fire:        pc_d = pred_pc;
      default:     pc_d = pc_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN:     if (s1_valid & !ic_rsp_vld) state_d = MISS;
      MISS:    if (ic_rsp_vld) state_d = RUN;
      default: state_d = BOOT;
    endcase
    if (redirect_en) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
    end
  end

  fetch_s1_reg u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .fire_i  (fire),
    .adv_i   (s1_adv),
    .flush_i (redirect_en),
    .grp_i   (grp_s0),
    .grp_o   (grp_s1),
    .valid_o (s1_valid),
    .flush_o (flush_s1)
  );

  assign fq_pc          = grp_s1.pc;
  assign fq_vld         = grp_s1.vld;
  assign fq_pred_taken  = grp_s1.taken;
  assign fq_pred_target = grp_s1.target;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_fetch_pc_gen;

  localparam int          BOOT_CYC = 2;
  localparam logic [31:0] RPC      = 32'h1c00_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_s0;
  logic        btb_hit;
  logic [31:0] btb_target;
  logic [3:0]  inst_vld_s0;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        ic_req;
  logic        ic_req_rdy;
  logic        ic_rsp_vld;
  logic        fq_ready;
  logic        fq_push;
  logic [31:0] fq_pc;
  logic [3:0]  fq_vld;
  logic        fq_pred_taken;
  logic [31:0] fq_pred_target;
  logic        stage1_hold;
  logic        flush_s1;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_gen #(
    .RESET_PC (RPC),
    .BOOT_CYC (BOOT_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_s0          (pc_s0),
    .btb_hit        (btb_hit),
    .btb_target     (btb_target),
    .inst_vld_s0    (inst_vld_s0),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .ic_req         (ic_req),
    .ic_req_rdy     (ic_req_rdy),
    .ic_rsp_vld     (ic_rsp_vld),
    .fq_ready       (fq_ready),
    .fq_push        (fq_push),
    .fq_pc          (fq_pc),
    .fq_vld         (fq_vld),
    .fq_pred_taken  (fq_pred_taken),
    .fq_pred_target (fq_pred_target),
    .stage1_hold    (stage1_hold),
    .flush_s1       (flush_s1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: boot countdown, miss flag, one-deep stage1.
  int          m_boot_left;
  bit          m_miss;
  logic [31:0] m_pc;
  bit          m_s1v;
  logic [31:0] m_fpc;
  logic [3:0]  m_fvld;
  bit          m_ftaken;
  logic [31:0] m_ftgt;
  bit          m_flush;

  always @(negedge clk) begin : model
    bit           can_move;
    bit           e_req;
    bit           e_push;
    bit           fire;
    logic [31:0]  nxt;
    logic [104:0] e_vec;
    logic [104:0] a_vec;
    if (!rst_n) begin
      m_boot_left = BOOT_CYC;
      m_miss      = 0;
      m_pc        = RPC;
      m_s1v       = 0;
      m_fpc       = '0;
      m_fvld      = '0;
      m_ftaken    = 0;
      m_ftgt      = '0;
      m_flush     = 0;
    end
    can_move = !m_s1v || (ic_rsp_vld && fq_ready);
    e_req    = (m_boot_left == 0) && !m_miss && can_move
               && !redirect_en;
    e_push   = m_s1v && ic_rsp_vld && fq_ready && !redirect_en;
    e_vec = {m_pc, e_req, e_push, !can_move, m_flush,
             m_fpc, m_fvld, m_ftaken, m_ftgt};
    a_vec = {pc_s0, ic_req, fq_push, stage1_hold, flush_s1,
             fq_pc, fq_vld, fq_pred_taken, fq_pred_target};
    n_tests++;
    if (a_vec !== e_vec) begin
      n_fail++;
      $display("FAIL model t=%0t got pc=%h req=%b push=%b hold=%b fl=%b fpc=%h vld=%b tk=%b tgt=%h want pc=%h req=%b push=%b hold=%b fl=%b fpc=%h vld=%b tk=%b tgt=%h",
               $time, pc_s0, ic_req, fq_push, stage1_hold, flush_s1,
               fq_pc, fq_vld, fq_pred_taken, fq_pred_target,
               m_pc, e_req, e_push, !can_move, m_flush,
               m_fpc, m_fvld, m_ftaken, m_ftgt);
    end
    if (rst_n) begin
      fire = e_req && ic_req_rdy;
      nxt  = btb_hit ? btb_target
                     : (m_pc & 32'hffff_fff0) + 32'd16;
      m_flush = redirect_en && m_s1v;
      if (redirect_en) begin
        m_boot_left = 0;
        m_miss      = 0;
      end else if (m_boot_left > 0) begin
        m_boot_left--;
      end else if (!m_miss && m_s1v && !ic_rsp_vld) begin
        m_miss = 1;
      end else if (m_miss && ic_rsp_vld) begin
        m_miss = 0;
      end
      if (redirect_en) begin
        m_s1v = 0;
      end else if (fire) begin
        m_s1v    = 1;
        m_fpc    = m_pc;
        m_fvld   = inst_vld_s0;
        m_ftaken = btb_hit;
        m_ftgt   = nxt;
      end else if (can_move) begin
        m_s1v = 0;
      end
      if (redirect_en) m_pc = redirect_pc & ~32'd3;
      else if (fire)   m_pc = nxt;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic defaults();
    btb_hit     = 1'b0;
    btb_target  = '0;
    inst_vld_s0 = 4'b1111;
    redirect_en = 1'b0;
    redirect_pc = '0;
    ic_req_rdy  = 1'b1;
    ic_rsp_vld  = 1'b1;
    fq_ready    = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    defaults();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // boot idle then first fetch
    at_neg(); lit("boot_c0_req", 32'(ic_req), 0);
    cyc(); at_neg(); lit("boot_c1_req", 32'(ic_req), 0);
    cyc(); at_neg();
    lit("c2_req", 32'(ic_req), 1);
    lit("c2_pc", pc_s0, 32'h1c00_0000);
    lit("c2_push", 32'(fq_push), 0);
    cyc(); at_neg();
    lit("c3_pc", pc_s0, 32'h1c00_0010);
    lit("c3_push", 32'(fq_push), 1);
    lit("c3_fqpc", fq_pc, 32'h1c00_0000);
    lit("c3_vld", 32'(fq_vld), 32'hf);
    // redirect with unaligned low bits
    cyc();
    redirect_en = 1'b1;
    redirect_pc = 32'h1c00_0026;
    at_neg();
    lit("c4_pc", pc_s0, 32'h1c00_0020);
    lit("c4_push", 32'(fq_push), 0);
    lit("c4_req", 32'(ic_req), 0);
    cyc();
    redirect_en = 1'b0;
    btb_hit     = 1'b1;
    btb_target  = 32'h1c00_0100;
    inst_vld_s0 = 4'b0110;
    at_neg();
    lit("c5_pc", pc_s0, 32'h1c00_0024);
    lit("c5_flush", 32'(flush_s1), 1);
    lit("c5_req", 32'(ic_req), 1);
    cyc();
    btb_hit     = 1'b0;
    inst_vld_s0 = 4'b1111;
    at_neg();
    lit("c6_pc", pc_s0, 32'h1c00_0100);
    lit("c6_vld", 32'(fq_vld), 32'b0110);
    lit("c6_taken", 32'(fq_pred_taken), 1);
    lit("c6_tgt", fq_pred_target, 32'h1c00_0100);
    lit("c6_push", 32'(fq_push), 1);
    // three-cycle miss
    for (int i = 0; i < 3; i++) begin
      cyc();
      ic_rsp_vld = 1'b0;
      at_neg();
      lit("miss_hold", 32'(stage1_hold), 1);
      lit("miss_push", 32'(fq_push), 0);
      lit("miss_pc", pc_s0, 32'h1c00_0110);
    end
    cyc();
    ic_rsp_vld = 1'b1;
    at_neg();
    lit("miss_end_push", 32'(fq_push), 1);
    lit("miss_end_fqpc", fq_pc, 32'h1c00_0100);
    lit("miss_end_req", 32'(ic_req), 0);
    cyc(); at_neg();
    lit("c11_req", 32'(ic_req), 1);
    lit("c11_pc", pc_s0, 32'h1c00_0110);
    // redirect while in MISS
    cyc();
    ic_rsp_vld = 1'b0;
    at_neg();
    lit("c12_hold", 32'(stage1_hold), 1);
    cyc();
    redirect_en = 1'b1;
    redirect_pc = 32'h1c00_0800;
    at_neg();
    lit("c13_push", 32'(fq_push), 0);
    cyc();
    redirect_en = 1'b0;
    ic_rsp_vld  = 1'b1;
    at_neg();
    lit("c14_flush", 32'(flush_s1), 1);
    lit("c14_pc", pc_s0, 32'h1c00_0800);
    lit("c14_req", 32'(ic_req), 1);
    // fetch queue back-pressure
    cyc();
    fq_ready = 1'b0;
    at_neg();
    lit("c15_hold", 32'(stage1_hold), 1);
    lit("c15_fqpc", fq_pc, 32'h1c00_0800);
    lit("c15_push", 32'(fq_push), 0);
    cyc();
    ic_rsp_vld = 1'b0;
    at_neg();
    lit("c16_fqpc", fq_pc, 32'h1c00_0800);
    lit("c16_vld", 32'(fq_vld), 32'hf);
    // async reset while missing
    cyc();
    rst_n = 1'b0;
    at_neg();
    lit("rst_pc", pc_s0, RPC);
    lit("rst_fqpc", fq_pc, 0);
    lit("rst_outs", {26'd0, ic_req, fq_push, stage1_hold,
                     flush_s1, fq_pred_taken, |fq_vld}, 0);
    defaults();
    cyc();
    rst_n       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'hffff_fffb;
    at_neg();
    lit("boot_redir_req", 32'(ic_req), 0);
    cyc();
    redirect_en = 1'b0;
    at_neg();
    lit("wrap_pc0", pc_s0, 32'hffff_fff8);
    lit("wrap_req", 32'(ic_req), 1);
    cyc(); at_neg();
    lit("wrap_pc1", pc_s0, 32'h0000_0000);
    lit("wrap_tgt", fq_pred_target, 32'h0000_0000);
    lit("wrap_push", 32'(fq_push), 1);
    // randomized run
    for (int c = 0; c < 4000; c++) begin
      cyc();
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(499) == 0) begin
        rst_n = 1'b0;
      end
      btb_hit     = ($urandom_range(3) == 0);
      btb_target  = $urandom;
      inst_vld_s0 = 4'($urandom);
      redirect_en = ($urandom_range(15) == 0);
      redirect_pc = ($urandom_range(3) == 0)
                  ? (32'hffff_ffe0 | 32'($urandom_range(31)))
                  : $urandom;
      ic_req_rdy  = ($urandom_range(7) != 0);
      ic_rsp_vld  = ($urandom_range(3) != 0);
      fq_ready    = ($urandom_range(3) != 0);
    end
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
